// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous, word-addressed instruction memory for the fetch stage.
// After reset the block is in LOAD and accepts program words through the prog_* port.
// prog_done moves it to RUN, where it serves byte-addressed PC fetches with one cycle
// of latency. A stall holds the outputs, and misaligned or out-of-range PCs raise a fault.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   prog_we/addr/data       program-load write (LOAD only, word aligned, in range)
//   prog_done               loader finished; LOAD -> RUN
//   fetch_req, pc, stall    fetch request, byte PC, pipeline stall (stall wins)
//   ready                   block is in RUN
//   instr_valid/instruction fetched word, or NOP
//   fault                   last accepted fetch was misaligned or out of range
//   load_count              accepted program writes since reset, saturating at DEPTH
module instr_mem_sync #(
   parameter int unsigned          DATA_W = 32,
   parameter int unsigned          DEPTH  = 256,
   parameter int unsigned          ADDR_W = 32,
   parameter logic [DATA_W-1:0]    NOP    = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         prog_we,
   input  logic [ADDR_W-1:0]            prog_addr,
   input  logic [DATA_W-1:0]            prog_data,
   input  logic                         prog_done,
   input  logic                         fetch_req,
   input  logic [ADDR_W-1:0]            pc,
   input  logic                         stall,
   output logic                         ready,
   output logic                         instr_valid,
   output logic [DATA_W-1:0]            instruction,
   output logic                         fault,
   output logic [$clog2(DEPTH):0]       load_count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

   state_t              state_q;
   logic                ready_q;
   logic                valid_q;
   logic [DATA_W-1:0]   instr_q;
   logic                fault_q;
   logic [CNT_W-1:0]    load_cnt_q;
   logic [CNT_W-1:0]    load_cnt_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [IDX_W-1:0]    prog_idx;
   logic [IDX_W-1:0]    pc_idx;
   logic                prog_ok;
   logic                pc_ok;
   logic                prog_wr;

   // Address decode: word index, alignment and range (no wrap onto low words)
   assign prog_idx = prog_addr[IDX_W+1:2];
   assign pc_idx   = pc[IDX_W+1:2];
   assign prog_ok  = (prog_addr[1:0] == 2'b00) && ((prog_addr >> 2) < ADDR_W'(DEPTH));
   assign pc_ok    = (pc[1:0] == 2'b00) && ((pc >> 2) < ADDR_W'(DEPTH));
   assign prog_wr  = (state_q == S_LOAD) && prog_we && prog_ok;

   // Saturating count of accepted program writes
   always_comb begin
      load_cnt_d = load_cnt_q;
      if (prog_wr && (load_cnt_q != CNT_W'(DEPTH))) begin
         load_cnt_d = load_cnt_q + CNT_W'(1);
      end
   end

   // Storage array: deliberately not reset so contents survive a control reset
   always_ff @(posedge clk) begin
      if (prog_wr) begin
         mem_q[prog_idx] <= prog_data;
      end
   end

   // Control FSM and registered fetch outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_LOAD;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= NOP;
         fault_q    <= 1'b0;
         load_cnt_q <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               load_cnt_q <= load_cnt_d;
               if (prog_done) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            S_RUN: begin
               // Stall freezes all three output registers
               if (!stall) begin
                  if (fetch_req && pc_ok) begin
                     instr_q <= mem_q[pc_idx];
                     valid_q <= 1'b1;
                     fault_q <= 1'b0;
                  end else begin
                     instr_q <= NOP;
                     valid_q <= 1'b0;
                     fault_q <= fetch_req;
                  end
               end
            end
            default: begin
               state_q <= S_LOAD;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready       = ready_q;
   assign instr_valid = valid_q;
   assign instruction = instr_q;
   assign fault       = fault_q;
   assign load_count  = load_cnt_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: each stimulus cycle pushes the expected post-edge
// outputs into a queue; a monitor pops and compares shortly after every rising edge.
module tb_instr_mem_sync;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOPW   = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic              prog_done;
   logic              fetch_req;
   logic [ADDR_W-1:0] pc;
   logic              stall;
   logic              ready;
   logic              instr_valid;
   logic [DATA_W-1:0] instruction;
   logic              fault;
   logic [CNT_W-1:0]  load_count;

   typedef struct packed {
      logic              rdy;
      logic              vld;
      logic [DATA_W-1:0] ins;
      logic              flt;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   step_no  = 0;

   instr_mem_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP(NOPW)) dut (
      .clk(clk), .reset(reset),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_done(prog_done),
      .fetch_req(fetch_req), .pc(pc), .stall(stall),
      .ready(ready), .instr_valid(instr_valid), .instruction(instruction),
      .fault(fault), .load_count(load_count)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input exp_t e);
      checks++;
      if (ready !== e.rdy || instr_valid !== e.vld || instruction !== e.ins ||
          fault !== e.flt || load_count !== e.cnt) begin
         failures++;
         $display("FAIL %s: got rdy=%b vld=%b ins=%h flt=%b cnt=%0d, need rdy=%b vld=%b ins=%h flt=%b cnt=%0d",
                  name, ready, instr_valid, instruction, fault, load_count,
                  e.rdy, e.vld, e.ins, e.flt, e.cnt);
      end
   endtask

   // Monitor: the DUT presents a result every cycle; compare it against the queue head
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         step_no++;
         compare($sformatf("step%0d", step_no), e);
      end
   end

   function automatic exp_t mk(input logic r, input logic v, input logic [31:0] i,
                               input logic f, input int c);
      exp_t e;
      e.rdy = r; e.vld = v; e.ins = i; e.flt = f; e.cnt = CNT_W'(c);
      return e;
   endfunction

   // One stimulus cycle: drive at the falling edge, record expected outputs after the rise
   task automatic step(input logic we, input logic [31:0] pa, input logic [31:0] pd,
                       input logic done, input logic fr, input logic [31:0] p,
                       input logic st, input exp_t e);
      @(negedge clk);
      prog_we = we; prog_addr = pa; prog_data = pd; prog_done = done;
      fetch_req = fr; pc = p; stall = st;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   initial begin
      reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_done = 1'b0;
      fetch_req = 1'b0; pc = '0; stall = 1'b0;
      #12;
      compare("reset_values", mk(0, 0, NOPW, 0, 0));
      @(negedge clk);
      reset = 1'b0;

      // LOAD: fetches ignored, bad writes dropped, good writes counted
      step(0, 0,    0,            0, 1, 0,   0, mk(0, 0, NOPW, 0, 0));
      step(1, 6,    32'hAAAA5555, 0, 0, 0,   0, mk(0, 0, NOPW, 0, 0));
      step(1, 1024, 32'h5555AAAA, 0, 0, 0,   0, mk(0, 0, NOPW, 0, 0));
      step(1, 0,    32'h20110001, 0, 1, 0,   0, mk(0, 0, NOPW, 0, 1));
      step(1, 4,    32'h2012000A, 0, 0, 0,   0, mk(0, 0, NOPW, 0, 2));
      step(1, 1020, 32'hDEADBEEF, 0, 0, 0,   0, mk(0, 0, NOPW, 0, 3));
      // Write together with prog_done still completes
      step(1, 8,    32'h02329820, 1, 0, 0,   0, mk(1, 0, NOPW, 0, 4));

      // RUN: write attempt ignored, back-to-back fetches
      step(1, 0, 32'hFFFFFFFF, 0, 1, 0,    0, mk(1, 1, 32'h20110001, 0, 4));
      step(0, 0, 0,            0, 1, 4,    0, mk(1, 1, 32'h2012000A, 0, 4));
      step(0, 0, 0,            0, 1, 8,    0, mk(1, 1, 32'h02329820, 0, 4));
      step(0, 0, 0,            0, 1, 0,    0, mk(1, 1, 32'h20110001, 0, 4));
      step(0, 0, 0,            0, 1, 1020, 0, mk(1, 1, 32'hDEADBEEF, 0, 4));
      // Faults: misaligned, first out-of-range word, then recovery
      step(0, 0, 0,            0, 1, 2,    0, mk(1, 0, NOPW, 1, 4));
      step(0, 0, 0,            0, 1, 1024, 0, mk(1, 0, NOPW, 1, 4));
      step(0, 0, 0,            0, 1, 0,    0, mk(1, 1, 32'h20110001, 0, 4));
      // Bubble
      step(0, 0, 0,            0, 0, 0,    0, mk(1, 0, NOPW, 0, 4));
      // Stall priority: hold for 3 cycles while pc changes
      step(0, 0, 0,            0, 1, 4,    0, mk(1, 1, 32'h2012000A, 0, 4));
      step(0, 0, 0,            0, 1, 8,    1, mk(1, 1, 32'h2012000A, 0, 4));
      step(0, 0, 0,            0, 0, 8,    1, mk(1, 1, 32'h2012000A, 0, 4));
      step(0, 0, 0,            0, 1, 1026, 1, mk(1, 1, 32'h2012000A, 0, 4));
      step(0, 0, 0,            0, 1, 8,    0, mk(1, 1, 32'h02329820, 0, 4));
      // Stall also holds a fault
      step(0, 0, 0,            0, 1, 3,    0, mk(1, 0, NOPW, 1, 4));
      step(0, 0, 0,            0, 0, 0,    1, mk(1, 0, NOPW, 1, 4));
      // prog_done in RUN has no effect
      step(0, 0, 0,            1, 0, 0,    0, mk(1, 0, NOPW, 0, 4));
      step(0, 0, 0,            0, 1, 4,    0, mk(1, 1, 32'h2012000A, 0, 4));

      // Asynchronous reset between edges during a fetch stream
      @(negedge clk);
      fetch_req = 1'b1; pc = 32'd8;
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      compare("async_reset", mk(0, 0, NOPW, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      // Still in LOAD until prog_done: fetch ignored
      step(0, 0, 0,            0, 1, 8,    0, mk(0, 0, NOPW, 0, 0));
      step(0, 0, 0,            1, 0, 0,    0, mk(1, 0, NOPW, 0, 0));
      step(0, 0, 0,            0, 1, 8,    0, mk(1, 1, 32'h02329820, 0, 0));
      step(0, 0, 0,            0, 1, 1020, 0, mk(1, 1, 32'hDEADBEEF, 0, 0));
      step(0, 0, 0,            0, 0, 0,    0, mk(1, 0, NOPW, 0, 0));

      // Drain the scoreboard with a bounded wait
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, need 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
